// File: rtl/ifu.sv
// ifu: instruction fetch unit; owns the PC, fetches words in order over req/gnt/rvalid,
//      buffers them in a prefetch FIFO and presents one instruction (or a zero bubble) per cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req_o / imem_addr_o   fetch request and word address (bits [1:0] always 0)
//   imem_gnt_i                 request accepted when high together with imem_req_o
//   imem_rvalid_i/imem_rdata_i in-order response valid and instruction word
//   flush_from_exe/_addr_exe   execute redirect (highest priority)
//   flush_from_dec/_addr_dec   decode redirect
//   stall_i                    hold the output registers
//   instr_ifu_2_dec_o          instruction to decoder, 32'h0 = bubble
//   instr_addr_ifu_2_dec_o     its address, 0 with a bubble
//   perf_fetch_cnt_o / perf_bubble_cnt_o  only when IFU_PERF_CNT_EN is defined
//
// Build option: define IFU_PERF_CNT_EN to add presented-instruction and bubble counters.
module ifu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        flush_from_exe,
    input  logic [31:0] flush_addr_exe,
    input  logic        flush_from_dec,
    input  logic [31:0] flush_addr_dec,
    input  logic        stall_i,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_bubble_cnt_o,
`endif
    output logic [31:0] instr_ifu_2_dec_o,
    output logic [31:0] instr_addr_ifu_2_dec_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {BOOT, FETCH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, aw_q, aw_d, ar_q, ar_d;
    logic [31:0]   instr_q, instr_d, iaddr_q, iaddr_d;
    logic [31:0]   fifo_word_q [FIFO_DEPTH];
    logic [31:0]   fifo_addr_q [FIFO_DEPTH];
    logic [31:0]   aq_q        [FIFO_DEPTH];

    logic          flush, gnt, push, pop;
    logic [31:0]   target;
    logic [CW:0]   inflight;

    assign flush    = flush_from_exe | flush_from_dec;
    assign target   = (flush_from_exe ? flush_addr_exe : flush_addr_dec) & ~32'h3;
    // buffered words plus outstanding fetches (including stale ones) bound the FIFO fill
    assign inflight = {1'b0, cnt_q} + {1'b0, out_q};

    assign imem_req_o  = (state_q == FETCH) && (inflight < (CW+1)'(FIFO_DEPTH)) && !flush;
    assign imem_addr_o = fpc_q;

    assign gnt  = imem_req_o & imem_gnt_i;
    // responses to requests issued before a flush are stale while disc_q is non-zero
    assign push = imem_rvalid_i && (disc_q == '0) && !flush;
    assign pop  = !stall_i && !flush && (cnt_q != '0);

    assign instr_ifu_2_dec_o      = instr_q;
    assign instr_addr_ifu_2_dec_o = iaddr_q;

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT) state_d = FETCH;
        fpc_d   = flush ? target : (gnt ? fpc_q + 32'd4 : fpc_q);
        out_d   = out_q + CW'(gnt) - CW'(imem_rvalid_i);
        // on a flush every request still in flight after this cycle becomes stale
        disc_d  = flush ? out_d : ((imem_rvalid_i && disc_q != '0) ? disc_q - CW'(1) : disc_q);
        cnt_d   = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        wp_d    = flush ? '0 : wp_q + AW'(push);
        rp_d    = flush ? '0 : rp_q + AW'(pop);
        aw_d    = flush ? '0 : aw_q + AW'(gnt);
        ar_d    = flush ? '0 : ar_q + AW'(push);
        instr_d = flush ? '0 : (stall_i ? instr_q : (pop ? fifo_word_q[rp_q] : '0));
        iaddr_d = flush ? '0 : (stall_i ? iaddr_q : (pop ? fifo_addr_q[rp_q] : '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            fpc_q   <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            aw_q    <= '0;
            ar_q    <= '0;
            instr_q <= '0;
            iaddr_q <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            aw_q    <= aw_d;
            ar_q    <= ar_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
        end
    end

    // storage needs no reset: pointers and counters qualify every read
    always_ff @(posedge clk) begin
        if (gnt) aq_q[aw_q] <= fpc_q;
        if (push) begin
            fifo_word_q[wp_q] <= imem_rdata_i;
            fifo_addr_q[wp_q] <= aq_q[ar_q];
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] pf_q, pb_q;

    assign perf_fetch_cnt_o  = pf_q;
    assign perf_bubble_cnt_o = pb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_q <= '0;
            pb_q <= '0;
        end else begin
            pf_q <= pf_q + 32'(pop);
            pb_q <= pb_q + 32'(!stall_i && !pop);
        end
    end
`endif
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu with an in-order latency-programmable memory model.
module tb_ifu;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 0, rvalid = 0;
    logic [31:0] rdata = 0;
    logic        fe = 0, fd = 0, stall = 0;
    logic [31:0] fae = 0, fad = 0;
    logic [31:0] instr, iaddr;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] pf, pb;
`endif

    always #5 clk = ~clk;

    ifu #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .flush_from_exe(fe), .flush_addr_exe(fae),
        .flush_from_dec(fd), .flush_addr_dec(fad),
        .stall_i(stall),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt_o(pf), .perf_bubble_cnt_o(pb),
`endif
        .instr_ifu_2_dec_o(instr), .instr_addr_ifu_2_dec_o(iaddr)
    );

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {logic [31:0] a; int due;} pend_t;
    pend_t       pend[$];
    logic [31:0] expq[$];
    int          cyc = 0, lat = 1, lastdue = 0, presented = 0, bubbles = 0, maxo = 0, maxb = 0;
    logic [31:0] exp_fpc = 0, prev_i = 0, prev_a = 0, prev_addr = 0;
    logic        prev_hold = 0, prev_wait = 0;
    logic        n_gnt = 0, n_stall = 0, n_fe = 0, n_fd = 0;
    logic [31:0] n_fae = 0, n_fad = 0;

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        gnt = n_gnt; stall = n_stall; fe = n_fe; fd = n_fd; fae = n_fae; fad = n_fad;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1;
            rdata = pend[0].a ^ 32'hA5A5_0000;
            void'(pend.pop_front());
        end else begin
            rvalid = 0;
            rdata = 0;
        end
        #1;
        if (prev_hold) begin
            check("hold_instr", instr, prev_i);
            check("hold_addr", iaddr, prev_a);
        end else if (instr == 0) begin
            check("bubble_addr", iaddr, 0);
            bubbles++;
        end else if (expq.size() == 0) begin
            check("unexpected_instr", instr, 0);
        end else begin
            e = expq.pop_front();
            check("out_addr", iaddr, e);
            check("out_data", instr, e ^ 32'hA5A5_0000);
            presented++;
        end
        if (prev_wait && !fe && !fd) begin
            check("req_stable", req, 1);
            check("addr_stable", addr, prev_addr);
        end
        prev_hold = stall;
        prev_i = instr;
        prev_a = iaddr;
        if (fe || fd) begin
            check("req_in_flush", req, 0);
            expq.delete();
            exp_fpc = (fe ? fae : fad) & ~32'h3;
            prev_hold = 0;
        end
        prev_wait = req && !gnt;
        prev_addr = addr;
        if (req && gnt) begin
            check("fetch_addr", addr, exp_fpc);
            expq.push_back(exp_fpc);
            lastdue = (cyc + lat > lastdue) ? cyc + lat : lastdue + 1;
            pend.push_back('{exp_fpc, lastdue});
            exp_fpc += 4;
        end
        if (pend.size() > maxo) maxo = pend.size();
        if (expq.size() > maxb) maxb = expq.size();
    endtask

    initial begin
        int p0, b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req", req, 0);
        check("reset_addr", addr, 32'h0);
        check("reset_instr", instr, 0);
        check("reset_iaddr", iaddr, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("boot_no_req", req, 0);

        n_gnt = 1;
        tick();
        check("first_req", req, 1);
        repeat (12) tick();
        p0 = presented;
        repeat (10) tick();
        check("throughput", presented - p0, 10);

        n_gnt = 0;
        b0 = bubbles;
        repeat (5) tick();
        n_gnt = 1;
        repeat (12) tick();
        check("gnt_gap_bubbles", 32'(bubbles > b0), 1);

        lat = 6;
        maxo = 0;
        p0 = presented;
        repeat (40) tick();
        check("lat6_max_outstanding", 32'(maxo <= DEPTH), 1);
        check("lat6_progress", 32'(presented - p0 >= 12), 1);

        n_gnt = 0;
        lat = 10;
        for (int i = 0; i < 60 && (pend.size() > 0 || expq.size() > 0); i++) tick();
        check("drained", pend.size() + expq.size(), 0);
        repeat (2) tick();
        n_gnt = 1;
        repeat (3) tick();
        n_gnt = 0;
        n_fe = 1;
        n_fae = 32'h103;
        tick();
        n_fe = 0;
        check("inflight_at_flush", pend.size(), 3);
        lat = 1;
        n_gnt = 1;
        tick();
        check("flush_bubble", instr, 0);
        check("flush_target_addr", addr, 32'h100);
        p0 = presented;
        repeat (25) tick();
        check("post_flush_progress", 32'(presented > p0), 1);

        n_fe = 1; n_fae = 32'h200;
        n_fd = 1; n_fad = 32'h300;
        tick();
        n_fe = 0; n_fd = 0;
        check("dual_flush_rvalid", rvalid, 1);
        tick();
        check("dual_flush_addr", addr, 32'h200);
        repeat (10) tick();

        maxb = 0;
        n_stall = 1;
        repeat (4) tick();
        n_stall = 0;
        repeat (15) tick();
        check("stall_fill", maxb, DEPTH);

        n_gnt = 0;
        repeat (10) tick();
        check("final_drain", expq.size(), 0);
`ifdef IFU_PERF_CNT_EN
        check("perf_fetch", pf, presented);
        check("perf_bubble", pb, bubbles);
`endif

        n_gnt = 1;
        repeat (5) tick();
        #2 rst_n = 0;
        #1;
        check("midreset_req", req, 0);
        check("midreset_addr", addr, 32'h0);
        check("midreset_instr", instr, 0);
        check("midreset_iaddr", iaddr, 0);
        pend.delete();
        expq.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
